// File: rtl/scorehand_pkg.sv
// Shared card encoding and value helper for the baccarat hand scorer.
package scorehand_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_NONE = 4'd0;
  localparam card_t CARD_A    = 4'd1;
  localparam card_t CARD_K    = 4'd13;

  // Pip cards count at face value; tens and court cards count zero.
  function automatic logic [3:0] card_value(input card_t code);
    logic [3:0] v;
    if ((code >= CARD_A) && (code <= 4'd9)) begin
      v = code;
    end else begin
      v = 4'd0;
    end
    return v;
  endfunction

endpackage

// File: rtl/card_value_map.sv
// Combinational card code to baccarat value, with a legality flag.
module card_value_map
  import scorehand_pkg::*;
(
  input  card_t      card,
  output logic [3:0] value,
  output logic       valid
);

  assign value = card_value(card);
  assign valid = (card >= CARD_A) && (card <= CARD_K);

endmodule

// File: rtl/scorehand_acc.sv
// Multi-hand baccarat accumulator: stores dealt cards per hand and keeps a
// running mod-10 score, card count and natural/full flags.
module scorehand_acc
  import scorehand_pkg::*;
#(
  parameter  int NUM_HANDS = 2,
  parameter  int MAX_CARDS = 3,
  localparam int HW        = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  localparam int CW        = $clog2(MAX_CARDS + 1)
) (
  input  logic                    slow_clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load_valid,
  input  logic [HW-1:0]           load_hand,
  input  logic [3:0]              load_card,
  output logic                    load_ready,
  output logic                    load_err,
  input  logic [HW-1:0]           rd_hand,
  input  logic [CW-1:0]           rd_slot,
  output logic [3:0]              rd_card,
  output logic [NUM_HANDS*4-1:0]  score,
  output logic [NUM_HANDS*CW-1:0] count,
  output logic [NUM_HANDS-1:0]    natural,
  output logic [NUM_HANDS-1:0]    full
);

  localparam logic [HW:0] NH = (HW+1)'(NUM_HANDS);

  logic [3:0]             value_s;
  logic                   valid_s;
  logic                   hand_ok_s;
  logic                   sel_full_s;
  logic                   accept_s;
  logic                   reject_s;
  logic                   err_r;
  logic [NUM_HANDS*4-1:0] rd_vec_s;

  card_value_map u_map (
    .card  (load_card),
    .value (value_s),
    .valid (valid_s)
  );

  // Full flag of the addressed hand; out-of-range hands are gated by hand_ok_s.
  always_comb begin
    sel_full_s = 1'b0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (load_hand == HW'(h)) begin
        sel_full_s = full[h];
      end else begin
        sel_full_s = sel_full_s;
      end
    end
  end

  assign hand_ok_s  = ({1'b0, load_hand} < NH);
  assign load_ready = !clear && hand_ok_s && !sel_full_s;
  assign accept_s   = load_valid && load_ready && valid_s;
  assign reject_s   = load_valid && load_ready && !valid_s;
  assign load_err   = err_r;

  // One-cycle error pulse for an illegal code offered while ready.
  always_ff @(posedge slow_clock) begin
    if (reset || clear) begin
      err_r <= 1'b0;
    end else begin
      err_r <= reject_s;
    end
  end

  for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
    logic [3:0]    slot_r [MAX_CARDS];
    logic [3:0]    score_r;
    logic [CW-1:0] count_r;
    logic          natural_r;
    logic          full_r;
    logic          hit_s;
    logic [4:0]    sum_s;
    logic [3:0]    score_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic [3:0]    rd_s;

    assign hit_s       = accept_s && (load_hand == HW'(h));
    assign sum_s       = {1'b0, score_r} + {1'b0, value_s};
    assign score_nxt_s = (sum_s >= 5'd10) ? 4'(sum_s - 5'd10) : sum_s[3:0];
    assign count_nxt_s = count_r + CW'(1);

    // Append the accepted card at the next free slot; flags track the new state.
    always_ff @(posedge slow_clock) begin
      if (reset || clear) begin
        for (int s = 0; s < MAX_CARDS; s++) begin
          slot_r[s] <= 4'd0;
        end
        score_r   <= 4'd0;
        count_r   <= '0;
        natural_r <= 1'b0;
        full_r    <= 1'b0;
      end else if (hit_s) begin
        for (int s = 0; s < MAX_CARDS; s++) begin
          if (count_r == CW'(s)) begin
            slot_r[s] <= load_card;
          end
        end
        score_r   <= score_nxt_s;
        count_r   <= count_nxt_s;
        natural_r <= (count_nxt_s == CW'(2)) && (score_nxt_s >= 4'd8);
        full_r    <= (count_nxt_s == CW'(MAX_CARDS));
      end
    end

    // Slot read; unused slots hold zero, indices past MAX_CARDS return zero.
    always_comb begin
      rd_s = 4'd0;
      for (int s = 0; s < MAX_CARDS; s++) begin
        if (rd_slot == CW'(s)) begin
          rd_s = slot_r[s];
        end else begin
          rd_s = rd_s;
        end
      end
    end

    assign score[4*h +: 4]    = score_r;
    assign count[CW*h +: CW]  = count_r;
    assign natural[h]         = natural_r;
    assign full[h]            = full_r;
    assign rd_vec_s[4*h +: 4] = rd_s;
  end

  // Hand select for the read port.
  always_comb begin
    rd_card = 4'd0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (rd_hand == HW'(h)) begin
        rd_card = rd_vec_s[4*h +: 4];
      end else begin
        rd_card = rd_card;
      end
    end
  end

endmodule

// File: tb/tb_scorehand_acc.sv
// Self-checking bench for scorehand_acc: directed scenarios plus random traffic
// compared against a card-list reference model.
module tb_scorehand_acc;

  localparam int NH = 2;
  localparam int MC = 3;
  localparam int HW = 1;
  localparam int CW = 2;

  logic            slow_clock = 1'b0;
  logic            reset = 1'b1;
  logic            clear = 1'b0;
  logic            load_valid = 1'b0;
  logic [HW-1:0]   load_hand = '0;
  logic [3:0]      load_card = 4'd0;
  logic            load_ready;
  logic            load_err;
  logic [HW-1:0]   rd_hand = '0;
  logic [CW-1:0]   rd_slot = '0;
  logic [3:0]      rd_card;
  logic [NH*4-1:0] score;
  logic [NH*CW-1:0] count;
  logic [NH-1:0]   natural;
  logic [NH-1:0]   full;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the list of cards held by each hand, plus the error pulse.
  int m_cnt [NH];
  int m_cards [NH][MC];
  int m_err;

  scorehand_acc #(.NUM_HANDS(NH), .MAX_CARDS(MC)) dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .clear      (clear),
    .load_valid (load_valid),
    .load_hand  (load_hand),
    .load_card  (load_card),
    .load_ready (load_ready),
    .load_err   (load_err),
    .rd_hand    (rd_hand),
    .rd_slot    (rd_slot),
    .rd_card    (rd_card),
    .score      (score),
    .count      (count),
    .natural    (natural),
    .full       (full)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int val_of(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int exp_score(input int h);
    int sum = 0;
    for (int i = 0; i < m_cnt[h]; i++) sum += val_of(m_cards[h][i]);
    return sum % 10;
  endfunction

  function automatic int exp_rd(input int h, input int s);
    return (s < m_cnt[h]) ? m_cards[h][s] : 0;
  endfunction

  task automatic check_state();
    for (int h = 0; h < NH; h++) begin
      check_val($sformatf("score%0d", h), int'(score[4*h +: 4]), exp_score(h));
      check_val($sformatf("count%0d", h), int'(count[CW*h +: CW]), m_cnt[h]);
      check_val($sformatf("natural%0d", h), int'(natural[h]),
                (m_cnt[h] == 2 && exp_score(h) >= 8) ? 1 : 0);
      check_val($sformatf("full%0d", h), int'(full[h]), (m_cnt[h] == MC) ? 1 : 0);
    end
    check_val("load_err", int'(load_err), m_err);
  endtask

  // One cycle: apply inputs, check combinational outputs, advance model, check state.
  task automatic step(input bit rst, input bit clr, input bit v, input int h,
                      input int c, input int rh, input int rs);
    bit rdy;
    @(negedge slow_clock);
    reset      = rst;
    clear      = clr;
    load_valid = v;
    load_hand  = h[HW-1:0];
    load_card  = c[3:0];
    rd_hand    = rh[HW-1:0];
    rd_slot    = rs[CW-1:0];
    #1;
    rdy = !clr && (m_cnt[h] < MC);
    check_val("load_ready", int'(load_ready), int'(rdy));
    check_val("rd_card", int'(rd_card), exp_rd(rh, rs));
    if (rst || clr) begin
      for (int i = 0; i < NH; i++) m_cnt[i] = 0;
      m_err = 0;
    end else if (v && rdy) begin
      if (c >= 1 && c <= 13) begin
        m_cards[h][m_cnt[h]] = c;
        m_cnt[h]++;
        m_err = 0;
      end else begin
        m_err = 1;
      end
    end else begin
      m_err = 0;
    end
    @(posedge slow_clock);
    #1;
    check_state();
  endtask

  initial begin
    for (int i = 0; i < NH; i++) m_cnt[i] = 0;
    m_err = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 5, 0, 0);

    // Hand 0: 7, 8 -> 5; hand 1 untouched
    step(0, 0, 1, 0, 7, 0, 0);
    step(0, 0, 1, 0, 8, 0, 0);
    // Hand 1: K, 9 -> natural 9, then 5 -> 4, full
    step(0, 0, 1, 1, 13, 0, 1);
    step(0, 0, 1, 1, 9, 1, 0);
    step(0, 0, 1, 1, 5, 1, 1);
    // Offer to full hand: ignored, no error
    step(0, 0, 1, 1, 3, 1, 2);
    step(0, 0, 0, 0, 0, 1, 3);
    // Invalid codes to hand 0
    step(0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 14, 0, 2);
    step(0, 0, 1, 0, 15, 0, 2);
    step(0, 0, 0, 0, 0, 0, 0);
    // Clear beats a same-cycle load
    step(0, 1, 1, 0, 4, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Reset mid-sequence, then A,A,A
    step(0, 0, 1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 0, 2);
    step(0, 0, 0, 0, 0, 0, 2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit rst, clr, v;
      int c;
      rst = ($urandom_range(0, 63) == 0);
      clr = ($urandom_range(0, 15) == 0);
      v   = ($urandom_range(0, 3) != 0);
      c   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 13);
      step(rst, clr, v, $urandom_range(0, NH-1), c,
           $urandom_range(0, NH-1), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
